control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of CPU_Datapath.
- Generates the per-step control strobes that CPU_Datapath consumes: register/bus enables, Gra/Grb/Grc select, memory read/write, ALUSelection.
- Sequences fetch (T0–T2) and execute (T3–T7) for ld, ldi, st, addi, andi, ori, br, nop, halt.
- Decodes the opcode from IR[31:27].

Parameters:
- MEM_WAIT_CYCLES, 1: extra cycles each memory step is held (total step length = MEM_WAIT_CYCLES+1; 0 allowed).
- ALU_ADD, 5'b00001: ALUSelection code for add.
- ALU_AND, 5'b00101: ALUSelection code for and.
- ALU_OR, 5'b00110: ALUSelection code for or.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset, synchronous and active-high.
- IR  in  32  instruction register contents from datapath.
- CON_FF_Out  in  1  branch-condition flag from datapath.
- PCout, PCin, IncPC, MARin, Zin, ZLowout, MDRin, MDRread, MDRout, IRin, Yin, Cout, Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In, wren  out  1 each  datapath strobes, active-high.
- ALUSelection  out  5  ALU operation code.
- Run  out  1  high while sequencing; low in RESET/HALT.
- illegal_op  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- State register: RESET, T0..T7, HALT. Outputs are a Moore decode of state plus opcode; any strobe not listed for a step is 0; ALUSelection is 0 unless listed.
- clr=1: state<=RESET at the edge, and all outputs are forced 0 combinationally during the clr cycle. This applies from any state, including mid-wait; the wait counter is cleared.
- RESET: one cycle with Run=0, then T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: ZLowout, PCin, MDRread, MDRin; memory step.
  - T2: MDRout, IRin.
- T3 decodes IR[31:27]:
  - ld 00000:
    - T3 Grb, BAout, Yin.
    - T4 Cout, Zin, ALU_ADD.
    - T5 ZLowout, MARin.
    - T6 MDRread, MDRin; memory step.
    - T7 MDRout, Gra, Rin. Then T0. Total 8+2*MEM_WAIT_CYCLES cycles.
  - ldi 00001: T3, T4 as ld; T5 ZLowout, Gra, Rin. Then T0.
  - st 00010:
    - T3–T5 as ld.
    - T6 Gra, Rout, MDRin (MDRread=0).
    - T7 wren; memory step. Then T0.
  - addi 01100 / andi 01101 / ori 01110:
    - T3 Grb, Rout, Yin.
    - T4 Cout, Zin, ALU_ADD/ALU_AND/ALU_OR respectively.
    - T5 ZLowout, Gra, Rin. Then T0.
  - br 10011:
    - T3 Gra, Rout, CON_FF_In.
    - T4 PCout, Yin.
    - T5 Cout, Zin, ALU_ADD.
    - T6 ZLowout and PCin, only if CON_FF_Out=1 (sampled in T6). Then T0.
  - nop 11010: T3 asserts nothing, then T0.
  - halt 11011: T3 asserts nothing, then HALT. HALT holds Run=0 with all strobes 0 until clr.
  - Any other opcode: illegal_op=1 in T3 only, no other strobes, then T0.
- Memory steps: a wait counter loads MEM_WAIT_CYCLES on step entry. The state holds, with strobes held steady, until the counter reaches 0; advance on the following edge.
- IR is sampled only in T3..T7. A change of IR during fetch has no effect until T3.
- Run=1 in T0..T7.

Optional Feature:
- Macro: CU_RETIRE_CNT_EN.
- Defined:
  - Adds output retired_count[31:0], reset to 0 by clr.
  - Increments by 1 on every transition from a final execute step into T0, including nop, illegal and not-taken br. It does not increment on entry to HALT.
  - Wraps 32'hFFFFFFFF -> 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- MEM_WAIT_CYCLES=1, IR=32'h02800075 (ld R5,0x75(R0)) -> T0,T1x2,T2,T3..T5,T6x2,T7 = 10 cycles; Gra+Rin+MDRout asserted together only in the final cycle; ALUSelection=5'b00001 only in T4.
- IR=32'h0A800075 (ldi) -> 7 cycles; T5 asserts ZLowout,Gra,Rin; MDRread never high outside T1.
- IR=32'h98000000 (br) with CON_FF_Out=0 then 1 -> PCin low in T6 when 0, high in T6 when 1; 8 cycles each.
- IR=32'h12800000 (st) -> wren high exactly 2 cycles in T7, MDRread low in T6/T7.
- IR=32'h78000000 (illegal, mul) -> illegal_op pulses 1 cycle in T3, returns to T0; IR=32'hD8000000 (halt) -> Run=0 and all strobes 0 for 20+ cycles until clr.
- clr asserted mid-T6 wait of ld -> all outputs 0 that cycle; RESET next; T0 after one cycle. With CU_RETIRE_CNT_EN, retired_count=0 after clr and =3 after three nops.

Source files
------------

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Bundle between the hardwired control sequencer and
//               CPU_Datapath.
//               master : sequencer side (drives strobes, reads IR/CON_FF_Out)
//               slave  : datapath side (drives IR/CON_FF_Out, reads strobes)
//               Signals: IR[31:0], CON_FF_Out, twenty 1-bit datapath strobes,
//                        ALUSelection[4:0], Run, illegal_op.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON_FF_Out;
  logic        PCout, PCin, IncPC, MARin, Zin, ZLowout, MDRin, MDRread, MDRout, IRin;
  logic        Yin, Cout, Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In, wren;
  logic [4:0]  ALUSelection;
  logic        Run;
  logic        illegal_op;

  modport master (
    input  IR, CON_FF_Out,
    output PCout, PCin, IncPC, MARin, Zin, ZLowout, MDRin, MDRread, MDRout, IRin,
           Yin, Cout, Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In, wren,
           ALUSelection, Run, illegal_op
  );

  modport slave (
    output IR, CON_FF_Out,
    input  PCout, PCin, IncPC, MARin, Zin, ZLowout, MDRin, MDRread, MDRout, IRin,
           Yin, Cout, Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In, wren,
           ALUSelection, Run, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired control unit for CPU_Datapath. Sequences fetch
//               (T0-T2) and execute (T3-T7) for ld, ldi, st, addi, andi, ori,
//               br, nop and halt, decoding the opcode from IR[31:27].
// Ports       : clk           - system clock, rising edge
//               clr           - synchronous active-high reset
//               ctrl (master) - IR / CON_FF_Out in; strobes, ALUSelection,
//                               Run, illegal_op out
//               retired_count - instructions retired (only with
//                               CU_RETIRE_CNT_EN defined)
// Options     : `define CU_RETIRE_CNT_EN adds the retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int         MEM_WAIT_CYCLES = 1,
  parameter logic [4:0] ALU_ADD         = 5'b00001,
  parameter logic [4:0] ALU_AND         = 5'b00101,
  parameter logic [4:0] ALU_OR          = 5'b00110
) (
  input  wire logic              clk,
  input  wire logic              clr,
  control_sequencer_if.master    ctrl
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [31:0]            retired_count
`endif
);

  localparam int WW = (MEM_WAIT_CYCLES > 0) ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] C_WAIT_LOAD = WW'(MEM_WAIT_CYCLES);

  localparam logic [4:0] C_OP_LD   = 5'b00000;
  localparam logic [4:0] C_OP_LDI  = 5'b00001;
  localparam logic [4:0] C_OP_ST   = 5'b00010;
  localparam logic [4:0] C_OP_ADDI = 5'b01100;
  localparam logic [4:0] C_OP_ANDI = 5'b01101;
  localparam logic [4:0] C_OP_ORI  = 5'b01110;
  localparam logic [4:0] C_OP_BR   = 5'b10011;
  localparam logic [4:0] C_OP_NOP  = 5'b11010;
  localparam logic [4:0] C_OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [4:0]      opcode;

  // Opcode is only consulted in T3..T7, so IR changes during fetch are inert.
  assign opcode = ctrl.IR[31:27];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RESET;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    wait_d            = wait_q;
    ctrl.PCout        = 1'b0;  ctrl.PCin     = 1'b0;  ctrl.IncPC   = 1'b0;
    ctrl.MARin        = 1'b0;  ctrl.Zin      = 1'b0;  ctrl.ZLowout = 1'b0;
    ctrl.MDRin        = 1'b0;  ctrl.MDRread  = 1'b0;  ctrl.MDRout  = 1'b0;
    ctrl.IRin         = 1'b0;  ctrl.Yin      = 1'b0;  ctrl.Cout    = 1'b0;
    ctrl.Gra          = 1'b0;  ctrl.Grb      = 1'b0;  ctrl.Grc     = 1'b0;
    ctrl.Rin          = 1'b0;  ctrl.Rout     = 1'b0;  ctrl.BAout   = 1'b0;
    ctrl.CON_FF_In    = 1'b0;  ctrl.wren     = 1'b0;
    ctrl.ALUSelection = 5'b0;
    ctrl.Run          = 1'b0;
    ctrl.illegal_op   = 1'b0;

    // During a clr cycle every output stays at its zero default.
    if (!clr) begin
      ctrl.Run = (state_q != S_RESET) && (state_q != S_HALT);
      case (state_q)
        S_RESET: state_d = S_T0;
        S_T0: begin
          {ctrl.PCout, ctrl.MARin, ctrl.IncPC, ctrl.Zin} = 4'hF;
          state_d = S_T1;
          wait_d  = C_WAIT_LOAD;
        end
        S_T1: begin
          {ctrl.ZLowout, ctrl.PCin, ctrl.MDRread, ctrl.MDRin} = 4'hF;
          if (wait_q == '0) state_d = S_T2;
          else              wait_d  = wait_q - 1'b1;
        end
        S_T2: begin
          {ctrl.MDRout, ctrl.IRin} = 2'b11;
          state_d = S_T3;
        end
        S_T3: begin
          state_d = S_T4;
          case (opcode)
            C_OP_LD, C_OP_LDI, C_OP_ST:        {ctrl.Grb, ctrl.BAout, ctrl.Yin} = 3'b111;
            C_OP_ADDI, C_OP_ANDI, C_OP_ORI:    {ctrl.Grb, ctrl.Rout, ctrl.Yin}  = 3'b111;
            C_OP_BR:                           {ctrl.Gra, ctrl.Rout, ctrl.CON_FF_In} = 3'b111;
            C_OP_NOP:                          state_d = S_T0;
            C_OP_HALT:                         state_d = S_HALT;
            default: begin
              ctrl.illegal_op = 1'b1;
              state_d         = S_T0;
            end
          endcase
        end
        S_T4: begin
          state_d = S_T5;
          if (opcode == C_OP_BR) begin
            {ctrl.PCout, ctrl.Yin} = 2'b11;
          end else begin
            {ctrl.Cout, ctrl.Zin} = 2'b11;
            case (opcode)
              C_OP_ANDI: ctrl.ALUSelection = ALU_AND;
              C_OP_ORI:  ctrl.ALUSelection = ALU_OR;
              default:   ctrl.ALUSelection = ALU_ADD;
            endcase
          end
        end
        S_T5: begin
          state_d = S_T0;
          case (opcode)
            C_OP_LD, C_OP_ST: begin
              {ctrl.ZLowout, ctrl.MARin} = 2'b11;
              state_d = S_T6;
              // T6 is a memory step only for ld; loading for st is harmless.
              wait_d  = C_WAIT_LOAD;
            end
            C_OP_BR: begin
              {ctrl.Cout, ctrl.Zin} = 2'b11;
              ctrl.ALUSelection     = ALU_ADD;
              state_d               = S_T6;
            end
            default: {ctrl.ZLowout, ctrl.Gra, ctrl.Rin} = 3'b111;
          endcase
        end
        S_T6: begin
          state_d = S_T0;
          case (opcode)
            C_OP_LD: begin
              {ctrl.MDRread, ctrl.MDRin} = 2'b11;
              if (wait_q == '0) state_d = S_T7;
              else begin
                state_d = S_T6;
                wait_d  = wait_q - 1'b1;
              end
            end
            C_OP_ST: begin
              {ctrl.Gra, ctrl.Rout, ctrl.MDRin} = 3'b111;
              state_d = S_T7;
              wait_d  = C_WAIT_LOAD;
            end
            default: begin
              // Branch taken: the condition flag is sampled in this step.
              ctrl.ZLowout = ctrl.CON_FF_Out;
              ctrl.PCin    = ctrl.CON_FF_Out;
            end
          endcase
        end
        S_T7: begin
          state_d = S_T0;
          if (opcode == C_OP_ST) begin
            ctrl.wren = 1'b1;
            if (wait_q != '0) begin
              state_d = S_T7;
              wait_d  = wait_q - 1'b1;
            end
          end else begin
            {ctrl.MDRout, ctrl.Gra, ctrl.Rin} = 3'b111;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_RESET;
      endcase
    end
  end

`ifdef CU_RETIRE_CNT_EN
  logic [31:0] retired_count_q, retired_count_d;
  logic        retire_evt;

  // Retirement = leaving any execute step for T0; RESET->T0 and HALT entry excluded.
  assign retire_evt = (state_q >= S_T3) && (state_q <= S_T7) && (state_d == S_T0);

  always_comb begin
    retired_count_d = retired_count_q;
    if (retire_evt) retired_count_d = retired_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) retired_count_q <= '0;
    else     retired_count_q <= retired_count_d;
  end

  assign retired_count = retired_count_q;
`endif

endmodule
`default_nettype wire
